// File: rtl/nes_palette_loader.sv
// Palette loader: turns an HPS ioctl .pal download into paced 24-bit palette RAM writes.
// Optional feature: define PAL_LOADER_CHECKSUM_EN to add pal_checksum / pal_checksum_ref.
module nes_palette_loader #(
  parameter logic [7:0]  PAL_IOCTL_INDEX = 8'd2,
  parameter int unsigned WR_GAP          = 4,
  parameter int unsigned ENTRIES         = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        load_color,
  output logic [23:0] load_color_data,
  output logic [5:0]  load_color_index,
  output logic        busy,
  output logic        palette_valid,
  output logic        load_error
`ifdef PAL_LOADER_CHECKSUM_EN
  ,
  input  logic [15:0] pal_checksum_ref,
  output logic [15:0] pal_checksum
`endif
);

  localparam logic [6:0]  ENTRY_LIMIT = 7'(ENTRIES);
  localparam logic [3:0]  GAP_LOAD    = 4'(WR_GAP - 1);
  localparam logic [10:0] PAL_BYTES   = 11'd192;
  localparam logic [10:0] EMPH_BYTES  = 11'd1536;
  localparam logic [10:0] CNT_MAX     = 11'd2047;

  typedef enum logic [2:0] {IDLE, RECV, EMIT, GAP, CHECK} state_t;

  state_t      state;
  logic        sel, sel_q, rise, fall, active;
  logic        wr_hit, accept, violation, completes, ok;
  logic        addr_err, fall_pend;
  logic [10:0] byte_cnt;
  logic [1:0]  phase;
  logic [7:0]  r_q, g_q;
  logic [6:0]  entry_idx;
  logic [3:0]  gap_cnt;

  assign sel    = ioctl_download && (ioctl_index == PAL_IOCTL_INDEX);
  assign rise   = sel && !sel_q;
  assign fall   = !sel && sel_q;
  assign active = (state == RECV) || (state == EMIT) || (state == GAP);

  // Stall only when the next byte would complete an entry; R/G bytes flow during the gap.
  assign ioctl_wait = ((state == EMIT) || (state == GAP)) && (phase == 2'd2);

  // A strobe coinciding with the falling edge of the download still counts.
  assign wr_hit    = active && ioctl_wr && (sel || fall);
  assign accept    = wr_hit && !ioctl_wait;
  assign violation = wr_hit && ioctl_wait;
  assign completes = accept && (phase == 2'd2) && (entry_idx < ENTRY_LIMIT);

  always_comb begin
    ok = !addr_err && ((byte_cnt == PAL_BYTES) || (byte_cnt == EMPH_BYTES));
`ifdef PAL_LOADER_CHECKSUM_EN
    ok = ok && (pal_checksum == pal_checksum_ref);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      // Pretend sel was already high so a download in flight at reset is ignored until it ends.
      sel_q            <= 1'b1;
      load_color       <= 1'b0;
      load_color_data  <= '0;
      load_color_index <= '0;
      busy             <= 1'b0;
      palette_valid    <= 1'b0;
      load_error       <= 1'b0;
      addr_err         <= 1'b0;
      fall_pend        <= 1'b0;
      byte_cnt         <= '0;
      phase            <= '0;
      r_q              <= '0;
      g_q              <= '0;
      entry_idx        <= '0;
      gap_cnt          <= '0;
`ifdef PAL_LOADER_CHECKSUM_EN
      pal_checksum     <= '0;
`endif
    end else begin
      sel_q      <= sel;
      load_color <= 1'b0;

      if (accept) begin
        if (byte_cnt != CNT_MAX) byte_cnt <= byte_cnt + 11'd1;
        if (ioctl_addr != {14'd0, byte_cnt}) addr_err <= 1'b1;
        case (phase)
          2'd0:    begin r_q <= ioctl_dout; phase <= 2'd1; end
          2'd1:    begin g_q <= ioctl_dout; phase <= 2'd2; end
          default: phase <= 2'd0;
        endcase
        if (completes) load_color_data <= {r_q, g_q, ioctl_dout};
`ifdef PAL_LOADER_CHECKSUM_EN
        if (byte_cnt < PAL_BYTES) pal_checksum <= pal_checksum + {8'd0, ioctl_dout};
`endif
      end
      if (violation) addr_err <= 1'b1;
      if (fall && active) fall_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (rise) begin
            state         <= RECV;
            busy          <= 1'b1;
            palette_valid <= 1'b0;
            load_error    <= 1'b0;
            addr_err      <= 1'b0;
            fall_pend     <= 1'b0;
            byte_cnt      <= '0;
            phase         <= '0;
            entry_idx     <= '0;
`ifdef PAL_LOADER_CHECKSUM_EN
            pal_checksum  <= '0;
`endif
          end
        end
        RECV: begin
          if (completes) begin
            state            <= EMIT;
            load_color       <= 1'b1;
            load_color_index <= entry_idx[5:0];
          end else if (fall) begin
            state <= CHECK;
          end
        end
        EMIT: begin
          entry_idx <= entry_idx + 7'd1;
          gap_cnt   <= GAP_LOAD;
          if (WR_GAP > 1)              state <= GAP;
          else if (fall_pend || fall)  state <= CHECK;
          else                         state <= RECV;
        end
        GAP: begin
          gap_cnt <= gap_cnt - 4'd1;
          if (gap_cnt <= 4'd1) state <= (fall_pend || fall) ? CHECK : RECV;
        end
        CHECK: begin
          palette_valid <= ok;
          load_error    <= !ok;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nes_palette_loader.sv
// Directed bench for nes_palette_loader: table of download scenarios plus a mid-download reset sequence.
module tb_nes_palette_loader;
  localparam int unsigned WR_GAP = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        ioctl_wait, load_color, busy, palette_valid, load_error;
  logic [23:0] load_color_data;
  logic [5:0]  load_color_index;

  nes_palette_loader #(.PAL_IOCTL_INDEX(8'd2), .WR_GAP(WR_GAP), .ENTRIES(64)) dut (
    .clk(clk), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .load_color(load_color), .load_color_data(load_color_data), .load_color_index(load_color_index),
    .busy(busy), .palette_valid(palette_valid), .load_error(load_error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [23:0] exp_entry(input int k);
    exp_entry = {8'(k), 8'(k + 64), 8'(k + 128)};
  endfunction

  function automatic logic [7:0] byte_val(input int a);
    if (a < 192) byte_val = 8'((a / 3) + 64 * (a % 3));
    else         byte_val = 8'(a ^ 'h5A);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Bench-side monitors, cleared through clr.
  logic        clr = 1'b0;
  int          cyc = 0, bytes_acc = 0;
  int          pulse_cnt = 0, bad_pulse = 0, min_space = 1000, last_pulse = 0;
  int          max_bytes = 0, wait_bad = 0, busy_seen = 0;
  logic [23:0] last_data = '0;

  always @(posedge clk) begin
    cyc++;
    if (clr) bytes_acc = 0;
    else if (ioctl_wr && !ioctl_wait) bytes_acc++;
  end

  always @(negedge clk) begin
    if (clr) begin
      pulse_cnt = 0; bad_pulse = 0; min_space = 1000; max_bytes = 0; wait_bad = 0; busy_seen = 0;
    end else begin
      if (busy) busy_seen = 1;
      if (ioctl_wait && (bytes_acc % 3) != 2) wait_bad++;
      if (load_color) begin
        if (load_color_index != 6'(pulse_cnt) || load_color_data != exp_entry(pulse_cnt)) bad_pulse++;
        if (pulse_cnt > 0 && (cyc - last_pulse) < min_space) min_space = cyc - last_pulse;
        last_pulse = cyc;
        last_data  = load_color_data;
        if (bytes_acc > max_bytes) max_bytes = bytes_acc;
        pulse_cnt++;
      end
    end
  end

  task automatic clear_stats();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    @(negedge clk);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_bytes(input int first, input int last_excl, input int skip, input bit fast);
    for (int a = first; a < last_excl; a++) begin
      int guard = 0;
      while (ioctl_wait && guard < 100) begin
        ioctl_wr = 1'b0;
        @(negedge clk);
        guard++;
      end
      if (guard >= 100) begin
        check("wait_timeout", guard, 0);
        return;
      end
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'((skip >= 0 && a >= skip) ? a + 1 : a);
      ioctl_dout = byte_val(a);
      @(negedge clk);
      ioctl_wr = 1'b0;
      if (!fast) @(negedge clk);
    end
  endtask

  task automatic end_dl();
    int guard = 0;
    ioctl_download = 1'b0;
    @(negedge clk);
    while (busy && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) check("busy_timeout", guard, 0);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    string       name;
    int          len;
    int          skip;
    logic [7:0]  idx;
    bit          fast;
    int          exp_pulses;
    int          exp_valid;
    int          exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"slow192",  192,  -1, 8'd2, 1'b0, 64, 1, 0};
    vecs[1] = '{"fast192",  192,  -1, 8'd2, 1'b1, 64, 1, 0};
    vecs[2] = '{"emph1536", 1536, -1, 8'd2, 1'b1, 64, 1, 0};
    vecs[3] = '{"short190", 190,  -1, 8'd2, 1'b0, 63, 0, 1};
    vecs[4] = '{"addrskip", 192,  10, 8'd2, 1'b1, 64, 0, 1};
    vecs[5] = '{"otheridx", 192,  -1, 8'd0, 1'b1, 0,  0, 1};

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_load_color", int'(load_color), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_wait", int'(ioctl_wait), 0);
    check("rst_valid", int'(palette_valid), 0);
    check("rst_error", int'(load_error), 0);
    check("rst_data", int'(load_color_data), 0);

    for (int i = 0; i < 6; i++) begin
      clear_stats();
      start_dl(vecs[i].idx);
      send_bytes(0, vecs[i].len, vecs[i].skip, vecs[i].fast);
      end_dl();
      check({vecs[i].name, "_pulses"}, pulse_cnt, vecs[i].exp_pulses);
      check({vecs[i].name, "_bad_pulse"}, bad_pulse, 0);
      check({vecs[i].name, "_wait_bad"}, wait_bad, 0);
      check({vecs[i].name, "_late_pulse"}, int'(max_bytes <= 192), 1);
      check({vecs[i].name, "_valid"}, int'(palette_valid), vecs[i].exp_valid);
      check({vecs[i].name, "_error"}, int'(load_error), vecs[i].exp_err);
      check({vecs[i].name, "_busy_end"}, int'(busy), 0);
      if (vecs[i].exp_pulses > 1)
        check({vecs[i].name, "_spacing"}, int'(min_space >= int'(WR_GAP)), 1);
      if (vecs[i].exp_pulses == 64)
        check({vecs[i].name, "_last_data"}, int'(last_data), int'(24'h3F7FBF));
      if (vecs[i].exp_pulses == 0)
        check({vecs[i].name, "_busy_seen"}, busy_seen, 0);
    end

    // Reset one cycle after byte 50; the remainder of that download must be ignored.
    clear_stats();
    start_dl(8'd2);
    send_bytes(0, 51, -1, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("mid_rst_load_color", int'(load_color), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_wait", int'(ioctl_wait), 0);
    check("mid_rst_valid", int'(palette_valid), 0);
    check("mid_rst_error", int'(load_error), 0);
    check("mid_rst_data", int'(load_color_data), 0);
    check("mid_rst_index", int'(load_color_index), 0);
    clear_stats();
    send_bytes(51, 192, -1, 1'b0);
    end_dl();
    check("post_rst_pulses", pulse_cnt, 0);
    check("post_rst_busy_seen", busy_seen, 0);
    check("post_rst_error", int'(load_error), 0);

    clear_stats();
    start_dl(8'd2);
    send_bytes(0, 192, -1, 1'b1);
    end_dl();
    check("clean_pulses", pulse_cnt, 64);
    check("clean_bad_pulse", bad_pulse, 0);
    check("clean_valid", int'(palette_valid), 1);
    check("clean_error", int'(load_error), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
